// File: rtl/maquina_pkg.sv
// Shared encodings for the vending machine: outcome codes, controller and
// dispenser state encodings, and the dispenser output bundle.
package maquina_pkg;

  localparam logic [1:0] CMD_SALDO_INSUF  = 2'b00;
  localparam logic [1:0] CMD_TROCO_REC    = 2'b01;
  localparam logic [1:0] CMD_DOCE_COMP    = 2'b10;
  localparam logic [1:0] CMD_DOCE_E_TROCO = 2'b11;

  localparam logic [2:0] DS_IDLE     = 3'd0;
  localparam logic [2:0] DS_REFUSE   = 3'd1;
  localparam logic [2:0] DS_DISPENSE = 3'd2;
  localparam logic [2:0] DS_CHANGE   = 3'd3;
  localparam logic [2:0] DS_FINISH   = 3'd4;
  localparam logic [2:0] DS_FAULT    = 3'd5;

  // Vending-machine controller states (the upstream block issuing commands)
  localparam logic [2:0] VM_IDLE    = 3'd0;
  localparam logic [2:0] VM_COLLECT = 3'd1;
  localparam logic [2:0] VM_EVAL    = 3'd2;
  localparam logic [2:0] VM_ISSUE   = 3'd3;
  localparam logic [2:0] VM_WAIT    = 3'd4;

  typedef struct packed {
    logic cmd_ready;
    logic motor_on;
    logic coin_req;
    logic insuf;
    logic done;
    logic fault;
  } disp_out_t;

  localparam disp_out_t DISP_OUT_RST = disp_out_t'(6'b100000);

  // Moore decode of the next state; registered by the caller.
  function automatic disp_out_t disp_outputs(input logic [2:0] st, input logic req);
    disp_out_t o;
    o = '0;
    case (st)
      DS_IDLE:     o.cmd_ready = 1'b1;
      DS_REFUSE:   o.insuf     = 1'b1;
      DS_DISPENSE: o.motor_on  = 1'b1;
      DS_CHANGE:   o.coin_req  = req;
      DS_FINISH:   o.done      = 1'b1;
      DS_FAULT:    o.fault     = 1'b1;
      default:     o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ack_timer.sv
// Coin-acknowledge watchdog: counts cycles a coin request waits unanswered
// and flags the cycle on which the ACK_TMO-th such cycle elapses.
module ack_timer #(
  parameter int ACK_TMO = 15
) (
  input  logic c,
  input  logic r,
  input  logic clr_i,
  input  logic run_i,
  output logic tmo_o
);

  localparam int CW = $clog2(ACK_TMO + 1);
  localparam logic [CW-1:0] LAST = CW'(ACK_TMO - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (run_i && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  areg #(.W(CW), .RST('0)) u_cnt (.c(c), .r(r), .d(cnt_d), .q(cnt_q));

  assign tmo_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/areg.sv
// Generic asynchronous active-low reset register with a parameterised
// reset value; all state in the dispenser lives in instances of this.
module areg #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         c,
  input  logic         r,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge c or negedge r) begin
    if (!r) q <= RST;
    else    q <= d;
  end

endmodule

// File: rtl/dispenser_ctrl.sv
// Candy/change dispenser: takes one outcome command at a time, runs the motor,
// returns coins one by one with an ack watchdog, and pulses done.
module dispenser_ctrl
  import maquina_pkg::*;
#(
  parameter int MOTOR_CYC = 4,
  parameter int CHG_W     = 4,
  parameter int ACK_TMO   = 15
) (
  input  logic             c,
  input  logic             r,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_code,
  input  logic [CHG_W-1:0] cmd_chg,
  output logic             motor_on,
  output logic             coin_req,
  input  logic             coin_ack,
  output logic             insuf,
  output logic             done,
  output logic             fault
);

  localparam int MW = $clog2(MOTOR_CYC + 1);
  localparam logic [MW-1:0] MOT_LAST = MW'(MOTOR_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [CHG_W-1:0] chg_q, chg_d;
  logic [MW-1:0]    mcnt_q, mcnt_d;
  disp_out_t        out_q, out_d;
  logic             req_d;
  logic             tmo;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    chg_d   = chg_q;
    mcnt_d  = mcnt_q;
    req_d   = 1'b0;
    case (state_q)
      DS_IDLE: begin
        if (cmd_valid && out_q.cmd_ready) begin
          code_d = cmd_code;
          chg_d  = cmd_chg;
          mcnt_d = '0;
          case (cmd_code)
            CMD_SALDO_INSUF: state_d = DS_REFUSE;
            CMD_TROCO_REC: begin
              if (cmd_chg != '0) begin
                state_d = DS_CHANGE;
                req_d   = 1'b1;
              end else begin
                state_d = DS_FINISH;
              end
            end
            default: state_d = DS_DISPENSE;
          endcase
        end
      end
      DS_REFUSE: state_d = DS_FINISH;
      DS_DISPENSE: begin
        if (mcnt_q == MOT_LAST) begin
          if (code_q == CMD_DOCE_E_TROCO && chg_q != '0) begin
            state_d = DS_CHANGE;
            req_d   = 1'b1;
          end else begin
            state_d = DS_FINISH;
          end
        end else begin
          mcnt_d = mcnt_q + 1'b1;
        end
      end
      DS_CHANGE: begin
        // req low is the one-cycle gap between coins; acks seen then are ignored
        if (out_q.coin_req) begin
          if (coin_ack) begin
            if (chg_q != '0) chg_d = chg_q - 1'b1;
            if (chg_q <= CHG_W'(1)) state_d = DS_FINISH;
          end else if (tmo) begin
            state_d = DS_FAULT;
          end else begin
            req_d = 1'b1;
          end
        end else if (chg_q == '0) begin
          state_d = DS_FINISH;
        end else begin
          req_d = 1'b1;
        end
      end
      DS_FINISH: state_d = DS_IDLE;
      DS_FAULT:  state_d = DS_FAULT;
      default:   state_d = DS_IDLE;
    endcase
    out_d = disp_outputs(state_d, req_d);
  end

  areg #(.W(3),     .RST(DS_IDLE))      u_state (.c(c), .r(r), .d(state_d), .q(state_q));
  areg #(.W(2),     .RST(2'b00))        u_code  (.c(c), .r(r), .d(code_d),  .q(code_q));
  areg #(.W(CHG_W), .RST('0))           u_chg   (.c(c), .r(r), .d(chg_d),   .q(chg_q));
  areg #(.W(MW),    .RST('0))           u_mcnt  (.c(c), .r(r), .d(mcnt_d),  .q(mcnt_q));
  areg #(.W(6),     .RST(DISP_OUT_RST)) u_out   (.c(c), .r(r), .d(out_d),   .q(out_q));

  ack_timer #(.ACK_TMO(ACK_TMO)) u_ack_timer (
    .c     (c),
    .r     (r),
    .clr_i (req_d && !out_q.coin_req),
    .run_i (out_q.coin_req && !coin_ack),
    .tmo_o (tmo)
  );

  assign cmd_ready = out_q.cmd_ready;
  assign motor_on  = out_q.motor_on;
  assign coin_req  = out_q.coin_req;
  assign insuf     = out_q.insuf;
  assign done      = out_q.done;
  assign fault     = out_q.fault;

endmodule

// File: tb/tb_dispenser_ctrl.sv
// Directed bench for dispenser_ctrl: per-cycle expected output vectors,
// with coin_ack driven from the same table.
module tb_dispenser_ctrl;
  localparam logic [5:0] O_IDLE = 6'b100000, O_MOT = 6'b010000, O_REQ = 6'b001000,
                         O_INS = 6'b000100, O_DONE = 6'b000010, O_FLT = 6'b000001,
                         O_NONE = 6'b000000;

  logic c = 1'b0, r = 1'b0;
  logic cmd_valid = 1'b0, coin_ack = 1'b0;
  logic [1:0] cmd_code = 2'b00;
  logic [3:0] cmd_chg = 4'd0;
  logic cmd_ready, motor_on, coin_req, insuf, done, fault;
  logic [5:0] outs;
  logic [6:0] sq[$];
  int n_tests = 0, n_fail = 0;

  dispenser_ctrl #(.MOTOR_CYC(4), .CHG_W(4), .ACK_TMO(15)) dut (
    .c(c), .r(r), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_chg(cmd_chg), .motor_on(motor_on),
    .coin_req(coin_req), .coin_ack(coin_ack), .insuf(insuf),
    .done(done), .fault(fault)
  );

  always #5 c = ~c;
  assign outs = {cmd_ready, motor_on, coin_req, insuf, done, fault};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add(input logic ack, input logic [5:0] o, input int n);
    for (int i = 0; i < n; i++) sq.push_back({ack, o});
  endtask

  // Called at the negedge of the first cycle after acceptance.
  task automatic run_seq(input string tag);
    for (int i = 0; i < sq.size(); i++) begin
      chk($sformatf("%s[%0d]", tag, i + 1), 32'(outs), 32'(sq[i][5:0]));
      coin_ack = sq[i][6];
      @(negedge c);
    end
    coin_ack = 1'b0;
    sq.delete();
  endtask

  task automatic send(input logic [1:0] code, input logic [3:0] chg);
    @(negedge c);
    cmd_valid = 1'b1; cmd_code = code; cmd_chg = chg;
    @(negedge c);
    cmd_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge c);
    chk("rst_outs", 32'(outs & 6'b011111), 32'd0);
    r = 1'b1;
    @(negedge c);
    chk("post_rst", 32'(outs), 32'(O_IDLE));

    send(2'b00, 4'd0);
    add(0, O_INS, 1); add(0, O_DONE, 1); add(0, O_IDLE, 1);
    run_seq("refuse");

    send(2'b01, 4'd0);
    add(0, O_DONE, 1); add(0, O_IDLE, 1);
    run_seq("chg0");

    send(2'b11, 4'd3);
    add(0, O_MOT, 4);
    repeat (2) begin add(0, O_REQ, 1); add(1, O_REQ, 1); add(0, O_NONE, 1); end
    add(0, O_REQ, 1); add(1, O_REQ, 1); add(0, O_DONE, 1); add(0, O_IDLE, 1);
    run_seq("candy_chg3");

    send(2'b10, 4'd5);
    add(0, O_MOT, 4); add(0, O_DONE, 1); add(0, O_IDLE, 1);
    run_seq("candy_only");

    send(2'b11, 4'd0);
    add(0, O_MOT, 4); add(0, O_DONE, 1); add(0, O_IDLE, 1);
    run_seq("candy_chg0");

    // spurious ack while idle must not pre-pay a coin
    coin_ack = 1'b1;
    repeat (3) @(negedge c);
    chk("spur_idle", 32'(outs), 32'(O_IDLE));
    coin_ack = 1'b0;
    send(2'b01, 4'd1);
    add(0, O_REQ, 1); add(1, O_REQ, 1); add(0, O_DONE, 1); add(0, O_IDLE, 1);
    run_seq("spur_one");

    // ack held through the inter-coin gap must be ignored there
    send(2'b01, 4'd2);
    add(1, O_REQ, 1); add(1, O_NONE, 1); add(0, O_REQ, 1); add(1, O_REQ, 1);
    add(0, O_DONE, 1); add(0, O_IDLE, 1);
    run_seq("gap_ack");

    send(2'b01, 4'hF);
    for (int k = 0; k < 15; k++) begin
      add(1, O_REQ, 1);
      if (k < 14) add(0, O_NONE, 1);
    end
    add(0, O_DONE, 1); add(0, O_IDLE, 1);
    run_seq("chg_max");

    send(2'b10, 4'd0);
    chk("mid_mot1", 32'(outs), 32'(O_MOT));
    @(negedge c);
    chk("mid_mot2", 32'(outs), 32'(O_MOT));
    #1 r = 1'b0;
    #1 chk("mid_rst_async", 32'(outs & 6'b011111), 32'd0);
    @(negedge c);
    r = 1'b1;
    @(negedge c);
    add(0, O_IDLE, 3);
    run_seq("mid_rst_after");

    send(2'b01, 4'd2);
    add(0, O_REQ, 15); add(0, O_FLT, 1);
    run_seq("timeout");
    cmd_valid = 1'b1; cmd_code = 2'b10;
    add(0, O_FLT, 4);
    run_seq("fault_sticky");
    cmd_valid = 1'b0;
    #1 r = 1'b0;
    #1 chk("fault_rst", 32'(outs & 6'b011111), 32'd0);
    @(negedge c);
    r = 1'b1;
    @(negedge c);
    chk("fault_cleared", 32'(outs), 32'(O_IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
